// File: rtl/gpu_bg_pair_reader.sv
// Background pair fetch: one VRAM word per drawn pixel pair, split into 5:5:5+STP fields, pair order preserved.
// Latency: bypass pair accept N -> o_bgValid N+1; memory pair data at M -> o_bgValid M+1.
// Backpressure: o_reqReady is registered; it drops on a full tag queue, a pending read or a post-clear drain.

// Generic FIFO with synchronous flush; head word readable combinationally.
// Latency: push at N is visible at the head at N+1.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module gpu_bg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is only consumed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
endmodule

// Background pair reader: in-order tag queue plus returned-data queue feeding the blend stage.
// Latency: bypass accept N -> o_bgValid N+1; memory data at M -> o_bgValid M+1.
// Backpressure: o_bgValid/i_bgReady on the output; o_reqReady registered from next state only.
module gpu_bg_pair_reader #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_clear,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [9:0]  i_scrX_Mul2,
    input  logic [8:0]  i_scrY,
    input  logic        i_needBG,
    output logic        o_memReqValid,
    input  logic        i_memReqAck,
    output logic [17:0] o_memAddr,
    input  logic        i_memDataValid,
    input  logic [31:0] i_memData,
    output logic        o_bgValid,
    input  logic        i_bgReady,
    output logic [4:0]  o_rBG_L,
    output logic [4:0]  o_gBG_L,
    output logic [4:0]  o_bBG_L,
    output logic [4:0]  o_rBG_R,
    output logic [4:0]  o_gBG_R,
    output logic [4:0]  o_bBG_R,
    output logic        o_bit15_L,
    output logic        o_bit15_R,
    output logic        o_fromMem
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] tag_count;
    logic [CW-1:0] tag_count_n;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_n;
    logic          draining;
    logic          draining_n;
    logic          mem_req_n;
    logic          ready_n;

    logic          accept;
    logic          ack;
    logic          rsp;
    logic          data_push;
    logic          tag_pop;
    logic          data_pop;
    logic          tag_head;
    logic          tag_empty;
    logic          data_empty;
    logic [31:0]   data_head;
    logic [31:0]   bg_word;
    logic          unused_x0;

    // Pairs are word aligned; the odd-pixel bit of X never reaches the address.
    assign unused_x0 = i_scrX_Mul2[0];

    assign accept    = i_reqValid & o_reqReady & ~i_clear;
    assign ack       = o_memReqValid & i_memReqAck;
    assign rsp       = i_memDataValid & (outst != '0);
    assign data_push = rsp & ~draining & ~i_clear;

    assign o_bgValid = ~tag_empty & (~tag_head | ~data_empty);
    assign tag_pop   = o_bgValid & i_bgReady & ~i_clear;
    assign data_pop  = tag_pop & tag_head;

    gpu_bg_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (i_nrst),
        .flush    (i_clear),
        .push     (accept),
        .push_dat (i_needBG),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .empty    (tag_empty)
    );

    gpu_bg_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_data_fifo (
        .clk      (clk),
        .rst_n    (i_nrst),
        .flush    (i_clear),
        .push     (data_push),
        .push_dat (i_memData),
        .pop      (data_pop),
        .head_dat (data_head),
        .empty    (data_empty)
    );

    always_comb begin
        tag_count_n = tag_count;
        if (i_clear)                tag_count_n = '0;
        else if (accept && !tag_pop) tag_count_n = tag_count + 1'b1;
        else if (!accept && tag_pop) tag_count_n = tag_count - 1'b1;

        // Acks in the clear cycle still count, so their data is drained.
        outst_n = outst;
        if (ack && !rsp)      outst_n = outst + 1'b1;
        else if (!ack && rsp) outst_n = outst - 1'b1;

        mem_req_n = o_memReqValid;
        if (i_clear)                  mem_req_n = 1'b0;
        else if (accept && i_needBG)  mem_req_n = 1'b1;
        else if (ack)                 mem_req_n = 1'b0;

        draining_n = (i_clear | draining) & (outst_n != '0);
        ready_n    = (tag_count_n < DEPTH_C) & ~mem_req_n & ~draining_n;
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tag_count     <= '0;
            outst         <= '0;
            draining      <= 1'b0;
            o_memReqValid <= 1'b0;
            o_memAddr     <= '0;
            o_reqReady    <= 1'b0;
        end else begin
            tag_count     <= tag_count_n;
            outst         <= outst_n;
            draining      <= draining_n;
            o_memReqValid <= mem_req_n;
            o_reqReady    <= ready_n;
            if (accept && i_needBG) o_memAddr <= {i_scrY, i_scrX_Mul2[9:1]};
        end
    end

    assign o_fromMem = o_bgValid & tag_head;
    assign bg_word   = o_fromMem ? data_head : 32'd0;

    assign o_rBG_L   = bg_word[4:0];
    assign o_gBG_L   = bg_word[9:5];
    assign o_bBG_L   = bg_word[14:10];
    assign o_bit15_L = bg_word[15];
    assign o_rBG_R   = bg_word[20:16];
    assign o_gBG_R   = bg_word[25:21];
    assign o_bBG_R   = bg_word[30:26];
    assign o_bit15_R = bg_word[31];
endmodule

// File: tb/tb_gpu_bg_pair_reader.sv
// Randomized bench for gpu_bg_pair_reader: directed scenarios plus a random phase, all scored against an in-order pair model.
module tb_gpu_bg_pair_reader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_clear;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [9:0]  i_scrX_Mul2;
    logic [8:0]  i_scrY;
    logic        i_needBG;
    logic        o_memReqValid;
    logic        i_memReqAck;
    logic [17:0] o_memAddr;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_bgValid;
    logic        i_bgReady;
    logic [4:0]  o_rBG_L, o_gBG_L, o_bBG_L, o_rBG_R, o_gBG_R, o_bBG_R;
    logic        o_bit15_L, o_bit15_R, o_fromMem;

    always #5 clk = ~clk;

    gpu_bg_pair_reader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .i_nrst(i_nrst), .i_clear(i_clear),
        .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
        .i_scrX_Mul2(i_scrX_Mul2), .i_scrY(i_scrY), .i_needBG(i_needBG),
        .o_memReqValid(o_memReqValid), .i_memReqAck(i_memReqAck), .o_memAddr(o_memAddr),
        .i_memDataValid(i_memDataValid), .i_memData(i_memData),
        .o_bgValid(o_bgValid), .i_bgReady(i_bgReady),
        .o_rBG_L(o_rBG_L), .o_gBG_L(o_gBG_L), .o_bBG_L(o_bBG_L),
        .o_rBG_R(o_rBG_R), .o_gBG_R(o_gBG_R), .o_bBG_R(o_bBG_R),
        .o_bit15_L(o_bit15_L), .o_bit15_R(o_bit15_R), .o_fromMem(o_fromMem)
    );

    logic [32:0] dut_view;
    logic [53:0] all_outs;
    assign dut_view = {o_fromMem, o_rBG_L, o_gBG_L, o_bBG_L, o_bit15_L,
                       o_rBG_R, o_gBG_R, o_bBG_R, o_bit15_R};
    assign all_outs = {o_reqReady, o_memReqValid, o_memAddr, o_bgValid, dut_view};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] salt;

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        if (a == 18'h00A03) return 32'hFC1F_8001;
        return {a[13:0], a} ^ salt;
    endfunction

    function automatic logic [17:0] pair_addr(input logic [8:0] y, input logic [9:0] x);
        return 18'(int'(y) * 512 + int'(x) / 2);
    endfunction

    function automatic logic [15:0] px(input int p);
        logic [4:0] r, g, b;
        r = 5'(p % 32);
        g = 5'((p / 32) % 32);
        b = 5'((p / 1024) % 32);
        return {r, g, b, 1'(p / 32768)};
    endfunction

    function automatic logic [32:0] expect_of(input logic [31:0] w);
        int lo, hi;
        lo = int'(w % 32'd65536);
        hi = int'(w / 32'd65536);
        return {1'b1, px(lo), px(hi)};
    endfunction

    // ---------------- memory responder ----------------
    int          cyc = 0;
    int          ack_pct = 100, dly_min = 1, dly_max = 1;
    bit          hold_data = 0, stray_req = 0, stray_now = 0;
    logic [31:0] ret_w[$];
    int          ret_t[$];

    always @(posedge clk) cyc++;

    initial begin
        i_memReqAck = 0; i_memDataValid = 0; i_memData = 0;
        forever begin
            @(negedge clk);
            if (!i_nrst) begin
                ret_w.delete(); ret_t.delete();
            end else begin
                if (o_memReqValid && i_memReqAck) begin
                    ret_w.push_back(mem_word(o_memAddr));
                    ret_t.push_back(cyc + $urandom_range(dly_max, dly_min));
                end
                if (i_memDataValid && !stray_now && ret_w.size() > 0) begin
                    void'(ret_w.pop_front());
                    void'(ret_t.pop_front());
                end
            end
            @(posedge clk); #1;
            stray_now   = 0;
            i_memReqAck = i_nrst && o_memReqValid && ($urandom_range(100, 1) <= ack_pct);
            if (stray_req) begin
                i_memDataValid = 1; i_memData = 32'hDEAD_BEEF; stray_now = 1; stray_req = 0;
            end else if (i_nrst && !hold_data && ret_w.size() > 0 && ret_t[0] <= cyc) begin
                i_memDataValid = 1; i_memData = ret_w[0];
            end else begin
                i_memDataValid = 0; i_memData = $urandom;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [17:0] addr_q[$];
    int          acc_cyc[$], out_cyc[$], data_cyc[$];
    bit          out_mem[$];
    int          n_acc = 0, n_out = 0, mem_req_cycles = 0;
    logic [32:0] prev_view;
    bit          prev_stall = 0;

    always @(negedge clk) begin
        if (!i_nrst) begin
            exp_q.delete(); addr_q.delete(); prev_stall = 0;
        end else begin
            if (o_memReqValid) mem_req_cycles++;
            if (o_memReqValid && i_memReqAck) begin
                check_eq("mem_req_has_pair", 64'(addr_q.size() != 0), 64'd1);
                if (addr_q.size() != 0) check_eq("mem_addr", 64'(o_memAddr), 64'(addr_q.pop_front()));
            end
            if (i_memDataValid) data_cyc.push_back(cyc);
            if (i_clear) begin
                exp_q.delete(); addr_q.delete(); prev_stall = 0;
            end else begin
                if (prev_stall && o_bgValid) check_eq("hold_stable", 64'(dut_view), 64'(prev_view));
                if (o_bgValid && i_bgReady) begin
                    n_out++; out_cyc.push_back(cyc); out_mem.push_back(o_fromMem);
                    check_eq("out_has_pair", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) check_eq("out_pair", 64'(dut_view), 64'(exp_q.pop_front()));
                end
                if (i_reqValid && o_reqReady) begin
                    n_acc++; acc_cyc.push_back(cyc);
                    if (i_needBG) begin
                        exp_q.push_back(expect_of(mem_word(pair_addr(i_scrY, i_scrX_Mul2))));
                        addr_q.push_back(pair_addr(i_scrY, i_scrX_Mul2));
                    end else begin
                        exp_q.push_back(33'd0);
                    end
                end
                prev_stall = o_bgValid && !i_bgReady;
                prev_view  = dut_view;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [19:0] stim_q[$];

    task automatic add_pair(input bit need);
        logic [8:0] y;
        logic [9:0] x;
        y = 9'($urandom);
        x = 10'($urandom);
        stim_q.push_back({need, y, x});
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); out_cyc.delete(); data_cyc.delete(); out_mem.delete();
        n_acc = 0; n_out = 0; mem_req_cycles = 0;
    endtask

    task automatic stream(input int limit, input bit rnd_rdy, input bit rnd_clr, input int rst_at);
        bit acc;
        for (int t = 0; t < limit && stim_q.size() > 0; t++) begin
            i_reqValid = 1;
            {i_needBG, i_scrY, i_scrX_Mul2} = stim_q[0];
            if (rnd_rdy) i_bgReady = 1'($urandom_range(1, 0));
            i_clear = rnd_clr && ($urandom_range(29, 0) == 0);
            if (t == rst_at) begin
                #2 i_nrst = 0;
                #1 check_eq("async_reset_outputs", 64'(all_outs), 64'd0);
                stim_q.delete(); i_reqValid = 0; i_clear = 0;
                return;
            end
            @(negedge clk);
            acc = o_reqReady && !i_clear;
            @(posedge clk); #1;
            if (acc) void'(stim_q.pop_front());
        end
        i_reqValid = 0; i_clear = 0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ret_w.size() == 0 && !o_memReqValid) break;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early, bgs, nd;
        salt = $urandom;
        i_nrst = 0; i_clear = 0; i_reqValid = 0; i_scrX_Mul2 = 0; i_scrY = 0;
        i_needBG = 0; i_bgReady = 0;
        #2 check_eq("reset_outputs", 64'(all_outs), 64'd0);
        repeat (3) @(posedge clk);
        #1 i_nrst = 1;
        @(negedge clk); check_eq("ready_before_edge", 64'(o_reqReady), 64'd0);
        @(negedge clk); check_eq("ready_after_reset", 64'(o_reqReady), 64'd1);
        @(posedge clk); #1;

        // 1: three bypass pairs back to back
        clear_logs(); i_bgReady = 1;
        repeat (3) add_pair(0);
        stream(20, 0, 0, -1);
        wait_idle("t1_idle", 20);
        check_eq("t1_outputs", 64'(n_out), 64'd3);
        for (int i = 0; i < 3 && i < out_cyc.size() && i < acc_cyc.size(); i++)
            check_eq("t1_latency", 64'(out_cyc[i] - acc_cyc[i]), 64'd1);
        if (out_cyc.size() >= 3) check_eq("t1_consecutive", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
        check_eq("t1_no_mem_req", 64'(mem_req_cycles), 64'd0);

        // 2: single memory pair with the reference word
        clear_logs(); ack_pct = 100; dly_min = 1; dly_max = 1;
        stim_q.push_back({1'b1, 9'd5, 10'd6});
        stream(10, 0, 0, -1);
        @(negedge clk);
        check_eq("t2_req_valid", 64'(o_memReqValid), 64'd1);
        check_eq("t2_addr", 64'(o_memAddr), 64'h00A03);
        for (int t = 0; t < 20 && !o_bgValid; t++) @(negedge clk);
        check_eq("t2_left", 64'({o_rBG_L, o_gBG_L, o_bBG_L, o_bit15_L}), 64'({5'd1, 5'd0, 5'd0, 1'b1}));
        check_eq("t2_right", 64'({o_rBG_R, o_gBG_R, o_bBG_R, o_bit15_R}), 64'({5'd31, 5'd0, 5'd31, 1'b1}));
        check_eq("t2_from_mem", 64'(o_fromMem), 64'd1);
        wait_idle("t2_idle", 20);
        if (out_cyc.size() > 0 && data_cyc.size() > 0)
            check_eq("t2_mem_latency", 64'(out_cyc[0] - data_cyc[0]), 64'd1);

        // 3: need 1,0,1 with slow memory keeps order
        clear_logs(); dly_min = 5; dly_max = 5;
        add_pair(1); add_pair(0); add_pair(1);
        stream(40, 0, 0, -1);
        wait_idle("t3_idle", 80);
        check_eq("t3_outputs", 64'(n_out), 64'd3);
        if (out_mem.size() >= 3)
            check_eq("t3_order", 64'({out_mem[0], out_mem[1], out_mem[2]}), 64'(3'b101));

        // 4: consumer stalled, six offered, only DEPTH accepted
        clear_logs(); dly_min = 1; dly_max = 3; i_bgReady = 0;
        for (int i = 0; i < 6; i++) add_pair(1'(i % 2));
        stream(20, 0, 0, -1);
        @(negedge clk);
        check_eq("t4_accepted", 64'(n_acc), 64'(DEPTH));
        check_eq("t4_ready_low", 64'(o_reqReady), 64'd0);
        check_eq("t4_no_output", 64'(n_out), 64'd0);
        @(posedge clk); #1;
        i_bgReady = 1;
        stream(60, 0, 0, -1);
        wait_idle("t4_idle", 60);
        check_eq("t4_all_out", 64'(n_out), 64'd6);

        // 5: clear with two reads outstanding, words returned afterwards
        clear_logs(); hold_data = 1; dly_min = 1; dly_max = 1;
        add_pair(1); add_pair(1);
        stream(20, 0, 0, -1);
        repeat (3) @(posedge clk);
        #1 i_clear = 1;
        @(posedge clk);
        #1 i_clear = 0;
        @(negedge clk);
        check_eq("t5_bg_cleared", 64'(o_bgValid), 64'd0);
        check_eq("t5_ready_draining", 64'(o_reqReady), 64'd0);
        hold_data = 0; early = 0; bgs = 0; nd = 0;
        for (int t = 0; t < 40 && nd < 2; t++) begin
            @(negedge clk);
            if (o_reqReady) early++;
            if (o_bgValid) bgs++;
            if (i_memDataValid) nd++;
        end
        @(negedge clk);
        check_eq("t5_words", 64'(nd), 64'd2);
        check_eq("t5_ready_early", 64'(early), 64'd0);
        check_eq("t5_ready_back", 64'(o_reqReady), 64'd1);
        check_eq("t5_no_output", 64'(bgs + n_out), 64'd0);
        @(posedge clk); #1;

        // 6: stray data beat, then a normal read must not see it
        clear_logs(); stray_req = 1; bgs = 0;
        repeat (4) begin @(negedge clk); if (o_bgValid) bgs++; end
        check_eq("t6_stray_ignored", 64'(bgs), 64'd0);
        @(posedge clk); #1;
        add_pair(1);
        stream(20, 0, 0, -1);
        wait_idle("t6_idle", 30);
        check_eq("t6_one_out", 64'(n_out), 64'd1);

        // 6b: async reset in the middle of a random burst
        ack_pct = 70; dly_min = 1; dly_max = 4;
        repeat (20) add_pair(1'($urandom_range(1, 0)));
        stream(200, 1, 0, 12);
        repeat (2) @(posedge clk);
        #1 i_nrst = 1;
        @(negedge clk); check_eq("rst2_ready_low", 64'(o_reqReady), 64'd0);
        @(negedge clk); check_eq("rst2_ready_high", 64'(o_reqReady), 64'd1);
        @(posedge clk); #1;

        // random phase with stalls, random acks/latency and occasional clears
        clear_logs(); ack_pct = 60; dly_min = 1; dly_max = 6;
        repeat (300) add_pair(1'($urandom_range(1, 0)));
        stream(4000, 1, 1, -1);
        check_eq("rand_all_offered", 64'(stim_q.size()), 64'd0);
        i_bgReady = 1;
        wait_idle("rand_idle", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
